// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the digit-serial BCD arithmetic blocks.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    // Largest legal decimal digit and the correction that folds 10..19 back into 0..9.
    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with +6 decimal correction, reused once per serial step.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s_d,
    output logic               cout,
    output logic               bad
);

    logic [DIGIT_W:0] w_t;

    // Binary digit sum, then decimal correction; the correction wraps mod 16 on purpose.
    always_comb begin
        w_t  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, cin};
        cout = (w_t > {1'b0, BCD_MAX});
        s_d  = cout ? (w_t[DIGIT_W-1:0] + BCD_CORR) : w_t[DIGIT_W-1:0];
        bad  = (a_d > BCD_MAX) || (b_d > BCD_MAX);
    end

endmodule : bcd_digit_add

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, least-significant digit first.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for start; operands captured on the accepting edge
//  RUN   | one digit added per clock, NDIG cycles, busy=1
//  DONE  | single cycle; result is published and done pulses next cycle
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*NDIG-1:0] sum,
    output logic                    cout,
    output logic                    invalid
);

    localparam int W  = DIGIT_W * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    bcd_state_t r_state;
    bcd_state_t w_next;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic [W-1:0]       r_sum;
    logic [CW-1:0]      r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_done;
    logic               r_invalid;

    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic               w_busy;
    logic               w_in_bad;
    logic [DIGIT_W-1:0] w_s_d;
    logic               w_c;
    logic               w_bad;
    logic [W-1:0]       w_dig_top;

    bcd_digit_add u_digit (
        .a_d  (r_a[DIGIT_W-1:0]),
        .b_d  (r_b[DIGIT_W-1:0]),
        .cin  (r_carry),
        .s_d  (w_s_d),
        .cout (w_c),
        .bad  (w_bad)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the digit counter counts down and RUN ends at terminal count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state control strobes; start outside IDLE is simply dropped.
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            IDLE: w_load = start;
            RUN: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            DONE:    w_fin = 1'b1;
            default: ;
        endcase
    end

    // Scan every incoming digit so invalid is known the moment the operands are captured.
    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if ((a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)) begin
                w_in_bad = 1'b1;
            end
        end
    end

    // New digit enters the result register from the top so digit 0 lands at the bottom.
    always_comb begin
        w_dig_top = W'(w_s_d) << (W - DIGIT_W);
    end

    // Datapath: capture, serial digit steps, and publishing of the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a       <= a;
                r_b       <= b;
                r_res     <= '0;
                r_carry   <= 1'b0;
                r_cnt     <= CNT_LAST;
                r_invalid <= w_in_bad;
            end else if (w_step) begin
                r_a     <= r_a >> DIGIT_W;
                r_b     <= r_b >> DIGIT_W;
                r_res   <= (r_res >> DIGIT_W) | w_dig_top;
                r_carry <= w_c;
                r_cnt   <= r_cnt - 1'b1;
                // Already covered by the capture scan; the per-digit flag can only agree.
                r_invalid <= r_invalid | w_bad;
            end else if (w_fin) begin
                r_sum  <= r_res;
                r_cout <= r_carry;
                r_done <= 1'b1;
            end
        end
    end

    // Output drive.
    always_comb begin
        busy    = w_busy;
        done    = r_done;
        sum     = r_sum;
        cout    = r_cout;
        invalid = r_invalid;
    end

endmodule : bcd_serial_adder

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (NDIG=4) with an expected-result queue.
module tb_bcd_serial_adder;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    // Decimal reference for valid operands: plain integer addition.
    function automatic exp_t dec_model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        int dx = 0;
        int dy = 0;
        int s;
        for (int i = NDIG - 1; i >= 0; i--) begin
            dx = dx * 10 + int'(x[i*4 +: 4]);
            dy = dy * 10 + int'(y[i*4 +: 4]);
        end
        s = dx + dy;
        r.cout = (s >= 10000);
        s = s % 10000;
        for (int i = 0; i < NDIG; i++) begin
            r.sum[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        r.inv = 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < NDIG; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout, invalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
                     busy, done, sum, cout, invalid);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        q.push_back('{sum: 16'h5555, cout: 1'b0, inv: 1'b0});
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            n_checks++;
            if (busy !== 1'(c <= 3)) begin
                n_fail++;
                $display("FAIL latency_busy c=%0d: got %b, want %b", c, busy, 1'(c <= 3));
            end
            n_checks++;
            if (done !== 1'(c == 5)) begin
                n_fail++;
                $display("FAIL latency_done c=%0d: got %b, want %b", c, done, 1'(c == 5));
            end
            if (done === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                    n_fail++;
                    $display("FAIL latency_result: got sum=%h cout=%b inv=%b, want sum=%h cout=%b inv=%b",
                             sum, cout, invalid, e.sum, e.cout, e.inv);
                end
            end
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta [4] = '{16'h0999, 16'h9999, 16'h9999, 16'h00A5};
        logic [W-1:0] tb [4] = '{16'h0001, 16'h9999, 16'h0001, 16'h0001};
        exp_t         te [4] = '{'{16'h1000, 1'b0, 1'b0}, '{16'h9998, 1'b1, 1'b0},
                                 '{16'h0000, 1'b1, 1'b0}, '{16'h0106, 1'b0, 1'b1}};
        logic [W-1:0] va, vb, prev;
        exp_t         ve, e;
        bit           seen, moved;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                va = ta[i]; vb = tb[i]; ve = te[i];
            end else begin
                va = rand_bcd(); vb = rand_bcd(); ve = dec_model(va, vb);
            end
            q.push_back(ve);
            prev  = sum;
            a = va; b = vb; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (invalid !== ve.inv) begin
                n_fail++;
                $display("FAIL invalid_at_capture op%0d: got %b, want %b", i, invalid, ve.inv);
            end
            seen = 1'b0; moved = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                if (done === 1'b1) begin
                    seen = 1'b1;
                    e = q.pop_front();
                    n_checks++;
                    if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                        n_fail++;
                        $display("FAIL vector op%0d a=%h b=%h: got sum=%h cout=%b inv=%b, want sum=%h cout=%b inv=%b",
                                 i, va, vb, sum, cout, invalid, e.sum, e.cout, e.inv);
                    end
                end else begin
                    if (busy === 1'b1 && sum !== prev) moved = 1'b1;
                    @(negedge clk);
                end
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL vector_timeout op%0d: got no done, want done", i);
            end
            n_checks++;
            if (moved) begin
                n_fail++;
                $display("FAIL sum_stable_in_run op%0d: got sum changed, want held %h", i, prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n_done = 0;
        int   pos[2] = '{-1, -1};
        q.push_back(dec_model(16'h2468, 16'h1357));
        q.push_back(dec_model(16'h5000, 16'h5000));
        @(negedge clk);
        a = 16'h2468; b = 16'h1357; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                a = 16'h5000; b = 16'h5000;
            end
            if (c == 7) start = 1'b0;
            if (done === 1'b1) begin
                if (n_done < 2) pos[n_done] = c;
                n_done++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_checks++;
                    if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                        n_fail++;
                        $display("FAIL b2b_result%0d: got sum=%h cout=%b inv=%b, want sum=%h cout=%b inv=%b",
                                 n_done, sum, cout, invalid, e.sum, e.cout, e.inv);
                    end
                end
            end
        end
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, want 2", n_done);
        end
        n_checks++;
        if (pos[0] != 5 || pos[1] != 11) begin
            n_fail++;
            $display("FAIL b2b_done_position: got %0d,%0d, want 5,11", pos[0], pos[1]);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_queue: got %0d pending, want 0", q.size());
        end
        q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        int   n_done;
        for (int k = 0; k < 2; k++) begin
            q.push_back(k == 0 ? exp_t'{16'h1122, 1'b1, 1'b1} : dec_model(16'h0505, 16'h0505));
            @(negedge clk);
            a = (k == 0) ? 16'h9A11 : 16'h0505;
            b = (k == 0) ? 16'h1111 : 16'h0505;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                if (done === 1'b1) begin
                    seen = 1'b1;
                    e = q.pop_front();
                    n_checks++;
                    if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                        n_fail++;
                        $display("FAIL reset_mid_op%0d: got sum=%h cout=%b inv=%b, want sum=%h cout=%b inv=%b",
                                 k, sum, cout, invalid, e.sum, e.cout, e.inv);
                    end
                end else begin
                    @(negedge clk);
                end
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL reset_mid_timeout op%0d: got no done, want done", k);
            end
            if (k == 0) begin
                // Aborted operation: reset lands in its second RUN cycle.
                @(negedge clk);
                a = 16'h4444; b = 16'h4444; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                #1;
                n_checks++;
                if ({busy, done, sum, cout, invalid} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
                             busy, done, sum, cout, invalid);
                end
                repeat (2) @(negedge clk);
                rst = 1'b0;
                n_done = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (done === 1'b1) n_done++;
                end
                n_checks++;
                if (n_done != 0) begin
                    n_fail++;
                    $display("FAIL aborted_done: got %0d done pulses, want 0", n_done);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bcd_serial_adder

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Digit-serial multi-digit BCD adder. It is the addition counterpart to the team's BCD subtractor. It accepts two packed BCD operands on a start strobe and processes one decimal digit per clock, least-significant digit (LSD) first, applying +6 decimal correction. It reports a packed BCD sum, a decimal carry-out and an invalid-digit flag with a one-cycle done pulse. It sits in the arithmetic block beside the code converters and comparator.

Parameters:
NDIG, 4, number of BCD digits per operand (minimum 1).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; operands sampled on the rising edge where start=1 and busy=0.
a  input  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*NDIG  operand B, packed BCD, same packing.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result outputs are valid from this cycle.
sum  output  4*NDIG  packed BCD result.
cout  output  1  decimal carry out of the most-significant digit.
invalid  output  1  set if any digit of the captured a or b was greater than 9.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, all state is cleared: FSM=IDLE, busy=0, done=0, sum=0, cout=0, invalid=0, internal shift registers and carry=0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced for the aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: capture a and b into shift registers.
  - Clear the internal carry and the digit counter.
  - Compute invalid for the new operation from all captured digits.
  - Go to RUN; busy=1 from the next cycle.
- RUN, per cycle, for digit i = 0..NDIG-1:
  - t = a_i + b_i + carry, 5-bit unsigned.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1. Otherwise digit = t and carry = 0.
  - Digit shifts into the internal result register from the top; operands shift right by 4.
  - After digit NDIG-1, go to DONE.
- DONE (one cycle):
  - sum is loaded from the internal result register; cout = final carry.
  - done=1, busy=0. Next state is IDLE.
- Latency: start sampled at edge k. Digits are processed at edges k+1..k+NDIG. done is high for the cycle following edge k+NDIG+1.
- Throughput: one operation every NDIG+2 cycles.
- busy is high in RUN only. start is accepted only in IDLE; start asserted in RUN or DONE is ignored and not queued.
- sum, cout and invalid hold their values from the last completed operation until the next DONE. sum and cout do not change during RUN. invalid updates at capture.
- Invalid digits (>9) are still processed by the same rule; the result is then unspecified-but-deterministic per the formula, and invalid=1.
- Worst-case valid sum per digit is t = 9+9+1 = 19, which gives digit 9 with carry 1.

Decomposition:
- Shared package bcd_pkg holds:
  - DIGIT_W=4.
  - BCD_MAX=9.
  - BCD_CORR=6.
  - The state enumeration {IDLE, RUN, DONE}.
- One natural sub-module, bcd_digit_add. It is combinational: inputs a_d[3:0], b_d[3:0], cin; outputs s_d[3:0], cout, bad (a_d>9 or b_d>9). It is instantiated once and reused each RUN cycle.

Test Plan:
- NDIG=4, a=0x1234, b=0x4321, start pulse -> busy for 4 cycles, done 6 cycles after start edge; sum=0x5555, cout=0, invalid=0.
- a=0x0999, b=0x0001 -> sum=0x1000, cout=0 (carry ripples through three digits).
- a=0x9999, b=0x9999 -> sum=0x9998, cout=1; then a=0x9999, b=0x0001 -> sum=0x0000, cout=1.
- a=0x00A5, b=0x0001 -> invalid=1 at done; sum per formula = 0x0106, cout=0.
- start re-asserted every cycle during RUN/DONE -> exactly one done per accepted start; the second operation begins only after return to IDLE.
- rst asserted at the 2nd RUN cycle -> all outputs 0 immediately and asynchronously, no done; a fresh start afterwards completes correctly.
